// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: debounces N active-low buttons into short/long press events
// and round-robins them onto a single valid/ready event port.
module btn_event_arbiter #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 250000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_n,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic                     evt_long,
  output logic [N_BTN-1:0]         held,
  output logic                     ovf,
  input  logic                     clr_ovf
);
  localparam int BW = $clog2(N_BTN);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  localparam logic [2:0] IDLE = 3'd0, DEB_PRESS = 3'd1, PRESSED = 3'd2,
                         LONG_HELD = 3'd3, DEB_REL = 3'd4, DEB_REL_L = 3'd5;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

  logic [N_BTN-1:0] sync_q, p_q;
  logic [N_BTN-1:0] raise, raise_long, grant, drop, pend_q, pend_d, pend_long_q, pend_long_d;
  logic [BW-1:0]    ptr_q, gnt_idx, cand;
  logic             any_pend, free, take;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      p_q    <= '0;
    end else begin
      sync_q <= ~btn_n;
      p_q    <= sync_q;
    end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [2:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          p, deb_done, in_deb, rs, rl;
    assign p        = p_q[i];
    assign deb_done = cnt_q == DEB_LAST;
    assign in_deb   = st_q == DEB_PRESS || st_q == DEB_REL || st_q == DEB_REL_L;
    assign held[i]  = st_q != IDLE && st_q != DEB_PRESS;
    assign raise[i] = rs | rl;
    assign raise_long[i] = rl;
    always_comb begin
      st_d   = st_q;
      hold_d = hold_q;
      rs     = 1'b0;
      rl     = 1'b0;
      case (st_q)
        IDLE:      st_d = p ? DEB_PRESS : IDLE;
        DEB_PRESS: st_d = !p ? IDLE : deb_done ? PRESSED : DEB_PRESS;
        PRESSED:
          if (!p) st_d = DEB_REL;
          else if (hold_q == LONG_LAST) begin
            st_d = LONG_HELD;
            rl   = 1'b1;
          end else hold_d = hold_q + HW'(1);
        LONG_HELD: st_d = p ? LONG_HELD : DEB_REL_L;
        DEB_REL: begin
          st_d = p ? PRESSED : deb_done ? IDLE : DEB_REL;
          rs   = !p && deb_done;
        end
        DEB_REL_L: st_d = p ? LONG_HELD : deb_done ? IDLE : DEB_REL_L;
        default:   st_d = IDLE;
      endcase
      if (st_d == IDLE) hold_d = '0;
      cnt_d = (st_d == st_q && in_deb) ? cnt_q + CW'(1) : '0;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        hold_q <= '0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        hold_q <= hold_d;
      end
  end

  // Descending scan so the last hit is the nearest pending button at/after the pointer.
  always_comb begin
    gnt_idx  = '0;
    any_pend = 1'b0;
    cand     = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      cand = BW'((int'(ptr_q) + k) % N_BTN);
      if (pend_q[cand]) begin
        gnt_idx  = cand;
        any_pend = 1'b1;
      end
    end
  end

  assign free  = !evt_valid || evt_ready;
  assign take  = free && any_pend;
  assign grant = take ? (N_BTN'(1) << gnt_idx) : '0;
  assign drop  = raise & pend_q & ~grant;
  assign pend_d      = (pend_q & ~grant) | raise;
  assign pend_long_d = (raise & ~drop & raise_long) | (~(raise & ~drop) & pend_long_q);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_q      <= '0;
      pend_long_q <= '0;
      ptr_q       <= '0;
      evt_valid   <= 1'b0;
      evt_btn     <= '0;
      evt_long    <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      ovf         <= |drop ? 1'b1 : clr_ovf ? 1'b0 : ovf;
      if (take) begin
        evt_valid <= 1'b1;
        evt_btn   <= gnt_idx;
        evt_long  <= pend_long_q[gnt_idx];
        ptr_q     <= (gnt_idx == BW'(N_BTN - 1)) ? '0 : gnt_idx + BW'(1);
      end else if (free) evt_valid <= 1'b0;
    end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed scenarios plus random button traffic, checked every
// cycle against a run-length debounce / slot-and-pointer reference model.
module tb_btn_event_arbiter;
  localparam int N = 4, DEB = 4, LNG = 20;

  logic         clk = 0, rst = 1, evt_ready = 1, clr_ovf = 0;
  logic [N-1:0] btn_n = '1;
  logic         evt_valid, evt_long, ovf;
  logic [1:0]   evt_btn;
  logic [N-1:0] held;

  btn_event_arbiter #(.N_BTN(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_btn(evt_btn), .evt_long(evt_long), .held(held), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0;
  int lb[$], ll[$];
  bit seen_h0;

  // Reference: a button's debounced level flips once the synchronized input has
  // disagreed with it for DEB+1 consecutive samples; hold time accrues only on
  // agreeing samples while pressed and not yet long.
  int m_p1[N], m_p2[N], m_run[N], m_hold[N];
  bit m_dh[N], m_ld[N], m_pend[N], m_pl[N];
  bit m_valid, m_long, m_ovf;
  int m_btn, m_ptr;

  task automatic chk(string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_p1[i] = 0; m_p2[i] = 0; m_run[i] = 0; m_hold[i] = 0;
      m_dh[i] = 0; m_ld[i] = 0; m_pend[i] = 0; m_pl[i] = 0;
    end
    m_valid = 0; m_long = 0; m_ovf = 0; m_btn = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    bit rs[N], rl[N];
    bit free, drop;
    int g, p;
    free = !m_valid || evt_ready;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) begin
      rs[i] = 0; rl[i] = 0; p = m_p2[i];
      if (p != int'(m_dh[i])) begin
        if (m_run[i] == DEB) begin
          m_dh[i] = p[0]; m_run[i] = 0;
          if (p == 0) begin rs[i] = !m_ld[i]; m_hold[i] = 0; m_ld[i] = 0; end
        end else m_run[i]++;
      end else begin
        if (m_run[i] == 0 && m_dh[i] && !m_ld[i]) begin
          if (m_hold[i] == LNG - 1) begin rl[i] = 1; m_ld[i] = 1; end
          else m_hold[i]++;
        end
        m_run[i] = 0;
      end
    end
    if (free) begin
      if (g >= 0) begin m_valid = 1; m_btn = g; m_long = m_pl[g]; m_ptr = (g + 1) % N; end
      else m_valid = 0;
    end
    drop = 0;
    for (int i = 0; i < N; i++) begin
      if (rs[i] || rl[i]) begin
        if (m_pend[i] && !(free && g == i)) drop = 1;
        else begin m_pend[i] = 1; m_pl[i] = rl[i]; end
      end else if (free && g == i) m_pend[i] = 0;
    end
    if (drop) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    for (int i = 0; i < N; i++) begin m_p2[i] = m_p1[i]; m_p1[i] = int'(!btn_n[i]); end
  endtask

  initial begin
    logic [N-1:0] eh;
    forever begin
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++) eh[i] = m_dh[i];
        chk("evt_valid", evt_valid, m_valid);
        chk("evt_btn", evt_btn, m_btn);
        chk("evt_long", evt_long, m_long);
        chk("held", held, eh);
        chk("ovf", ovf, m_ovf);
        if (evt_valid && evt_ready) begin lb.push_back(evt_btn); ll.push_back(evt_long); end
        if (held[0]) seen_h0 = 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  function automatic int lbat(int i); return (i < lb.size()) ? lb[i] : -1; endfunction
  function automatic int llat(int i); return (i < ll.size()) ? ll[i] : -1; endfunction

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; btn_n = '1; evt_ready = 1; clr_ovf = 0;
    cyc(2);
    rst = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, evt_valid, 0);
    chk({tag, "_btn"}, evt_btn, 0);
    chk({tag, "_long"}, evt_long, 0);
    chk({tag, "_held"}, held, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    int n0, w, s;
    int dur[N];
    cyc(3);
    chk_zero("rst");
    rst = 0;
    cyc(2);

    do_reset(); n0 = lb.size();
    btn_n[1] = 0; cyc(10);
    chk("t1_held_on", held[1], 1);
    btn_n[1] = 1; cyc(12);
    chk("t1_count", lb.size() - n0, 1);
    chk("t1_btn", lbat(n0), 1);
    chk("t1_long", llat(n0), 0);
    chk("t1_held_off", held[1], 0);
    chk("t1_ovf", ovf, 0);

    do_reset(); n0 = lb.size(); seen_h0 = 0;
    repeat (5) begin btn_n[0] = 0; cyc(2); btn_n[0] = 1; cyc(1); end
    cyc(10);
    chk("t2_count", lb.size() - n0, 0);
    chk("t2_held_seen", seen_h0, 0);

    do_reset(); n0 = lb.size();
    btn_n[2] = 0; cyc(35);
    chk("t3_count_held", lb.size() - n0, 1);
    chk("t3_btn", lbat(n0), 2);
    chk("t3_long", llat(n0), 1);
    chk("t3_still_held", held[2], 1);
    cyc(5); btn_n[2] = 1; cyc(15);
    chk("t3_count_after", lb.size() - n0, 1);
    chk("t3_held_off", held[2], 0);

    do_reset(); evt_ready = 0; n0 = lb.size();
    btn_n = 4'b0100; cyc(10); btn_n = '1;
    w = 0;
    while (!evt_valid && w < 40) begin cyc(1); w++; end
    chk("t4_valid", evt_valid, 1);
    repeat (5) begin chk("t4_stall_btn", evt_btn, 0); chk("t4_stall_valid", evt_valid, 1); cyc(1); end
    evt_ready = 1; cyc(6);
    chk("t4_count", lb.size() - n0, 3);
    chk("t4_ord0", lbat(n0), 0);
    chk("t4_ord1", lbat(n0 + 1), 1);
    chk("t4_ord2", lbat(n0 + 2), 3);
    btn_n = 4'b0110; cyc(10); btn_n = '1; cyc(12);
    chk("t4_wrap0", lbat(n0 + 3), 0);
    chk("t4_wrap1", lbat(n0 + 4), 3);

    do_reset(); evt_ready = 0; n0 = lb.size();
    repeat (3) begin btn_n[1] = 0; cyc(10); btn_n[1] = 1; cyc(10); end
    cyc(5);
    chk("t5_valid", evt_valid, 1);
    chk("t5_btn", evt_btn, 1);
    chk("t5_ovf", ovf, 1);
    clr_ovf = 1; cyc(1); clr_ovf = 0;
    chk("t5_ovf_clr", ovf, 0);
    chk("t5_btn_kept", evt_btn, 1);
    evt_ready = 1; cyc(3);
    chk("t5_drained", lb.size() - n0, 2);

    do_reset(); evt_ready = 0;
    btn_n = 4'b1001; cyc(10); btn_n[1] = 1; cyc(10);
    chk("t6_pre_valid", evt_valid, 1);
    #2 rst = 1;
    #1 chk_zero("t6_async");
    cyc(2);
    rst = 0; evt_ready = 1; n0 = lb.size();
    w = 0;
    while (!evt_valid && w < 60) begin cyc(1); w++; end
    chk("t6_latency", w, 28);
    chk("t6_btn", evt_btn, 2);
    chk("t6_long", evt_long, 1);
    btn_n = '1; cyc(12);

    do_reset();
    for (int i = 0; i < N; i++) dur[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (dur[i] == 0) begin
          s = $urandom_range(0, 9);
          btn_n[i] = ~btn_n[i];
          dur[i] = s < 3 ? $urandom_range(1, 3) : s < 8 ? $urandom_range(6, 15) : $urandom_range(22, 40);
        end
        dur[i]--;
      end
      evt_ready = $urandom_range(0, 2) != 0;
      clr_ovf = $urandom_range(0, 19) == 0;
      cyc(1);
    end
    btn_n = '1; evt_ready = 1; clr_ovf = 0; cyc(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
